// File: rtl/bin_scan_scheduler.sv
// Display-select scheduler for three bins: round-robin scan, alarm pre-emption
// with hysteresis, and a single-outstanding collection request handshake.
module bin_scan_scheduler #(
    parameter int         DWELL     = 16,
    parameter logic [7:0] ALARM_ON  = 8'd230,
    parameter logic [7:0] ALARM_OFF = 8'd204
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bin1_cap,
    input  logic [7:0] bin2_cap,
    input  logic [7:0] bin3_cap,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic [2:0] alarm,
    output logic       collect_req,
    output logic [1:0] collect_bin,
    input  logic       collect_ack
);
    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic {SCAN, ALERT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    sel, sel_n;        // {bin3, bin2, bin1}
    logic [2:0]    alarm_r, alarm_n;
    logic          req, req_n;
    logic [1:0]    bin, bin_n;
    logic [2:0]    serviced, serviced_n;
    logic [2:0]    pending, ack_mask;
    logic [7:0]    cap [3];

    assign cap[0] = bin1_cap;
    assign cap[1] = bin2_cap;
    assign cap[2] = bin3_cap;

    function automatic logic [2:0] lowest(input logic [2:0] m);
        if (m[0])      return 3'b001;
        else if (m[1]) return 3'b010;
        else if (m[2]) return 3'b100;
        else           return 3'b000;
    endfunction

    // Next alarmed bin in cyclic order after cur; falls back to cur itself.
    function automatic logic [2:0] next_after(input logic [2:0] cur, input logic [2:0] m);
        logic [2:0] r1, r2;
        r1 = {cur[1:0], cur[2]};
        r2 = {cur[0], cur[2:1]};
        if ((r1 & m) != 3'b000)      return r1;
        else if ((r2 & m) != 3'b000) return r2;
        else                         return cur;
    endfunction

    function automatic logic [1:0] index_of(input logic [2:0] oh);
        if (oh[0])      return 2'd1;
        else if (oh[1]) return 2'd2;
        else if (oh[2]) return 2'd3;
        else            return 2'd0;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (cap[i] >= ALARM_ON)      alarm_n[i] = 1'b1;
            else if (cap[i] < ALARM_OFF) alarm_n[i] = 1'b0;
            else                         alarm_n[i] = alarm_r[i];
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = (cnt == LAST) ? '0 : cnt + CW'(1);
        case (state)
            SCAN: begin
                if (alarm_r != 3'b000) begin
                    state_n = ALERT;
                    sel_n   = lowest(alarm_r);
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    sel_n = {sel[1:0], sel[2]};
                end
            end
            ALERT: begin
                // Losing the current bin's alarm overrides dwell timing.
                if (alarm_r == 3'b000) begin
                    state_n = SCAN;
                    sel_n   = 3'b001;
                    cnt_n   = '0;
                end else if ((alarm_r & sel) == 3'b000 || cnt == LAST) begin
                    sel_n = next_after(sel, alarm_r);
                    cnt_n = '0;
                end
            end
            default: begin
                state_n = SCAN;
                sel_n   = 3'b001;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        req_n    = req;
        bin_n    = bin;
        ack_mask = 3'b000;
        pending  = alarm_r & ~serviced;
        if (req) begin
            if (collect_ack) begin
                req_n    = 1'b0;
                bin_n    = 2'd0;
                ack_mask = {bin == 2'd3, bin == 2'd2, bin == 2'd1};
            end
        end else if (pending != 3'b000) begin
            req_n = 1'b1;
            bin_n = index_of(lowest(pending));
        end
        // A bin becomes eligible again once its alarm has dropped.
        serviced_n = (serviced & alarm_r) | ack_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            cnt      <= '0;
            sel      <= 3'b001;
            alarm_r  <= 3'b000;
            req      <= 1'b0;
            bin      <= 2'd0;
            serviced <= 3'b000;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sel      <= sel_n;
            alarm_r  <= alarm_n;
            req      <= req_n;
            bin      <= bin_n;
            serviced <= serviced_n;
        end
    end

    assign sel1        = sel[0];
    assign sel2        = sel[1];
    assign sel3        = sel[2];
    assign alarm       = alarm_r;
    assign collect_req = req;
    assign collect_bin = bin;
endmodule

// File: tb/tb_bin_scan_scheduler.sv
// Directed table-driven bench for bin_scan_scheduler with DWELL=16.
module tb_bin_scan_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bin1_cap, bin2_cap, bin3_cap;
    logic       sel1, sel2, sel3;
    logic [2:0] alarm;
    logic       collect_req;
    logic [1:0] collect_bin;
    logic       collect_ack;

    int nvec = 0;
    int nbad = 0;

    bin_scan_scheduler #(.DWELL(16), .ALARM_ON(8'd230), .ALARM_OFF(8'd204)) dut (
        .clk(clk), .rst(rst),
        .bin1_cap(bin1_cap), .bin2_cap(bin2_cap), .bin3_cap(bin3_cap),
        .sel1(sel1), .sel2(sel2), .sel3(sel3),
        .alarm(alarm),
        .collect_req(collect_req), .collect_bin(collect_bin),
        .collect_ack(collect_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c1, c2, c3;
        logic       ack;
        int         adv;
        logic [2:0] sel;   // {sel3, sel2, sel1}
        logic [2:0] alm;
        logic       req;
        logic [1:0] bin;
    } vec_t;

    vec_t vt [40];

    function automatic vec_t mk(input logic [7:0] c1, c2, c3, input logic ack, input int adv,
                                input logic [2:0] sel, alm, input logic req, input logic [1:0] bin);
        vec_t v;
        v.c1 = c1; v.c2 = c2; v.c3 = c3; v.ack = ack; v.adv = adv;
        v.sel = sel; v.alm = alm; v.req = req; v.bin = bin;
        return v;
    endfunction

    task automatic check(input string name, input logic [2:0] esel, ealm,
                         input logic ereq, input logic [1:0] ebin);
        logic [8:0] act, exp;
        act = {sel3, sel2, sel1, alarm, collect_req, collect_bin};
        exp = {esel, ealm, ereq, ebin};
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got sel=%b alarm=%b req=%b bin=%0d, want sel=%b alarm=%b req=%b bin=%0d",
                     name, {sel3, sel2, sel1}, alarm, collect_req, collect_bin,
                     esel, ealm, ereq, ebin);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!$onehot({sel3, sel2, sel1})) begin
            nbad++;
            $display("FAIL onehot: got sel=%b, want exactly one bit set", {sel3, sel2, sel1});
        end
    endtask

    initial begin
        // Edge counts in comments are posedges since reset release.
        vt[0]  = mk(0,   0,   0,   0, 0,  3'b001, 3'b000, 0, 0);
        vt[1]  = mk(0,   0,   0,   0, 15, 3'b001, 3'b000, 0, 0);
        vt[2]  = mk(0,   0,   0,   0, 1,  3'b010, 3'b000, 0, 0);   // E16 rotate
        vt[3]  = mk(0,   0,   0,   0, 15, 3'b010, 3'b000, 0, 0);
        vt[4]  = mk(0,   0,   0,   0, 1,  3'b100, 3'b000, 0, 0);   // E32
        vt[5]  = mk(0,   0,   0,   0, 16, 3'b001, 3'b000, 0, 0);   // E48
        vt[6]  = mk(0,   0,   0,   0, 4,  3'b001, 3'b000, 0, 0);
        vt[7]  = mk(0,   242, 0,   0, 1,  3'b001, 3'b010, 0, 0);   // E53 alarm
        vt[8]  = mk(0,   242, 0,   0, 1,  3'b010, 3'b010, 1, 2);   // E54 display + req
        vt[9]  = mk(0,   242, 0,   0, 20, 3'b010, 3'b010, 1, 2);
        vt[10] = mk(0,   242, 0,   1, 1,  3'b010, 3'b010, 0, 0);   // ack edge
        vt[11] = mk(0,   242, 0,   0, 5,  3'b010, 3'b010, 0, 0);   // no re-request
        vt[12] = mk(0,   100, 0,   0, 1,  3'b010, 3'b000, 0, 0);
        vt[13] = mk(0,   100, 0,   0, 1,  3'b001, 3'b000, 0, 0);   // back to SCAN
        vt[14] = mk(230, 100, 0,   0, 1,  3'b001, 3'b001, 0, 0);
        vt[15] = mk(230, 100, 0,   0, 1,  3'b001, 3'b001, 1, 1);
        vt[16] = mk(210, 100, 0,   0, 2,  3'b001, 3'b001, 1, 1);   // hold band
        vt[17] = mk(203, 100, 0,   0, 1,  3'b001, 3'b000, 1, 1);   // clears
        vt[18] = mk(203, 100, 0,   0, 1,  3'b001, 3'b000, 1, 1);   // req not retracted
        vt[19] = mk(203, 100, 0,   1, 1,  3'b001, 3'b000, 0, 0);
        vt[20] = mk(203, 100, 0,   0, 3,  3'b001, 3'b000, 0, 0);
        vt[21] = mk(240, 0,   250, 0, 1,  3'b001, 3'b101, 0, 0);   // E93
        vt[22] = mk(240, 0,   250, 0, 1,  3'b001, 3'b101, 1, 1);   // E94 lowest first
        vt[23] = mk(240, 0,   250, 0, 15, 3'b001, 3'b101, 1, 1);
        vt[24] = mk(240, 0,   250, 0, 1,  3'b100, 3'b101, 1, 1);   // E110 dwell -> bin3
        vt[25] = mk(240, 0,   250, 1, 1,  3'b100, 3'b101, 0, 0);   // ack bin1
        vt[26] = mk(240, 0,   250, 0, 1,  3'b100, 3'b101, 1, 3);   // after idle cycle
        vt[27] = mk(240, 0,   250, 0, 13, 3'b100, 3'b101, 1, 3);
        vt[28] = mk(240, 0,   250, 0, 1,  3'b001, 3'b101, 1, 3);   // E126 wrap to bin1
        vt[29] = mk(100, 0,   100, 0, 1,  3'b001, 3'b000, 1, 3);
        vt[30] = mk(100, 0,   100, 0, 1,  3'b001, 3'b000, 1, 3);   // SCAN, req held
        vt[31] = mk(100, 0,   100, 0, 20, 3'b010, 3'b000, 1, 3);   // E148
        vt[32] = mk(100, 0,   100, 1, 1,  3'b010, 3'b000, 0, 0);
        vt[33] = mk(100, 0,   100, 1, 2,  3'b010, 3'b000, 0, 0);   // idle ack ignored
        vt[34] = mk(240, 240, 0,   0, 1,  3'b010, 3'b011, 0, 0);
        vt[35] = mk(240, 240, 0,   0, 1,  3'b001, 3'b011, 1, 1);
        vt[36] = mk(100, 240, 0,   0, 1,  3'b001, 3'b010, 1, 1);
        vt[37] = mk(100, 240, 0,   0, 1,  3'b010, 3'b010, 1, 1);   // current cleared -> next
        vt[38] = mk(100, 240, 0,   1, 1,  3'b010, 3'b010, 0, 0);
        vt[39] = mk(100, 240, 0,   0, 1,  3'b010, 3'b010, 1, 2);

        rst = 1'b1;
        bin1_cap = 8'd0; bin2_cap = 8'd0; bin3_cap = 8'd0;
        collect_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            bin1_cap    = vt[i].c1;
            bin2_cap    = vt[i].c2;
            bin3_cap    = vt[i].c3;
            collect_ack = vt[i].ack;
            for (int k = 0; k < vt[i].adv; k++) tick();
            check($sformatf("vec%0d", i), vt[i].sel, vt[i].alm, vt[i].req, vt[i].bin);
        end

        // Asynchronous reset in ALERT with a request pending.
        #2 rst = 1'b1;
        #1 check("async_rst", 3'b001, 3'b000, 1'b0, 2'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("post_rst_alarm", 3'b001, 3'b010, 1'b0, 2'd0);
        tick();
        check("post_rst_req", 3'b010, 3'b010, 1'b1, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
